// File: rtl/q_update_engine.sv
// Q-learning update controller: reads Q(s',*) and Q(s,a) from four action RAMs,
// applies the shift-based TD update and writes the saturated result back.
module q_update_engine #(
    parameter int A_SHIFT = 2,
    parameter int G_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  state,
    input  logic [1:0]  action,
    input  logic [5:0]  next_state,
    input  logic [15:0] reward,
    input  logic        terminal,
    output logic        busy,
    output logic        done,
    output logic [1:0]  best_action,
    output logic        ram_en,
    output logic [5:0]  ram_rd_addr,
    input  logic [63:0] ram_rd_data,
    output logic [5:0]  ram_wr_addr,
    output logic [15:0] ram_wr_data,
    output logic [3:0]  ram_wr_en
);

    typedef enum logic [2:0] {
        IDLE, RD_NEXT, CAP_NEXT, CAP_CUR, CALC, WRITE, DONE
    } st_t;

    localparam logic signed [17:0] QMAX = 18'sd32767;
    localparam logic signed [17:0] QMIN = -18'sd32768;

    st_t                st;
    logic [5:0]         s_q;
    logic [1:0]         a_q;
    logic [15:0]        r_q;
    logic               term_q;
    logic [15:0]        max_q;
    logic [15:0]        cur_q;
    logic [1:0]         arg_q;

    logic signed [15:0] mx;
    logic [1:0]         amx;
    logic signed [17:0] mq18, q18, r18, g18, tgt, dlt, sum;
    logic [15:0]        nq;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        mx  = $signed(ram_rd_data[15:0]);
        amx = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if ($signed(ram_rd_data[16*i +: 16]) > mx) begin
                mx  = $signed(ram_rd_data[16*i +: 16]);
                amx = 2'(i);
            end
        end
    end

    always_comb begin
        mq18 = {{2{max_q[15]}}, max_q};
        q18  = {{2{cur_q[15]}}, cur_q};
        r18  = {{2{r_q[15]}}, r_q};
        g18  = term_q ? 18'sd0 : mq18 - (mq18 >>> G_SHIFT);
        tgt  = r18 + g18;
        dlt  = tgt - q18;
        sum  = q18 + (dlt >>> A_SHIFT);
        if (sum > QMAX)
            nq = 16'h7FFF;
        else if (sum < QMIN)
            nq = 16'h8000;
        else
            nq = sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_action <= 2'd0;
            ram_en      <= 1'b0;
            ram_rd_addr <= 6'd0;
            ram_wr_addr <= 6'd0;
            ram_wr_data <= 16'd0;
            ram_wr_en   <= 4'd0;
            s_q         <= 6'd0;
            a_q         <= 2'd0;
            r_q         <= 16'd0;
            term_q      <= 1'b0;
            max_q       <= 16'd0;
            cur_q       <= 16'd0;
            arg_q       <= 2'd0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (start) begin
                        s_q         <= state;
                        a_q         <= action;
                        r_q         <= reward;
                        term_q      <= terminal;
                        busy        <= 1'b1;
                        ram_en      <= 1'b1;
                        ram_rd_addr <= next_state;
                        st          <= RD_NEXT;
                    end
                end
                RD_NEXT: begin
                    ram_rd_addr <= s_q;
                    st          <= CAP_NEXT;
                end
                CAP_NEXT: begin
                    max_q  <= mx;
                    arg_q  <= amx;
                    ram_en <= 1'b0;
                    st     <= CAP_CUR;
                end
                CAP_CUR: begin
                    cur_q <= ram_rd_data[16*a_q +: 16];
                    st    <= CALC;
                end
                CALC: begin
                    ram_wr_addr <= s_q;
                    ram_wr_data <= nq;
                    ram_wr_en   <= 4'b0001 << a_q;
                    st          <= WRITE;
                end
                WRITE: begin
                    ram_wr_en   <= 4'd0;
                    done        <= 1'b1;
                    best_action <= arg_q;
                    st          <= DONE;
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_update_engine.sv
// Bench for q_update_engine: behavioural RAM + update model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_q_update_engine;

    localparam int A = 2;
    localparam int G = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  state;
    logic [1:0]  action;
    logic [5:0]  next_state;
    logic [15:0] reward;
    logic        terminal;
    logic        busy;
    logic        done;
    logic [1:0]  best_action;
    logic        ram_en;
    logic [5:0]  ram_rd_addr;
    logic [63:0] ram_rd_data;
    logic [5:0]  ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic [3:0]  ram_wr_en;

    q_update_engine #(.A_SHIFT(A), .G_SHIFT(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .state(state),
        .action(action), .next_state(next_state), .reward(reward),
        .terminal(terminal), .busy(busy), .done(done),
        .best_action(best_action), .ram_en(ram_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_en(ram_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    logic [15:0] mem [4][64];

    // Four synchronous-read RAMs; output is zero when not enabled.
    always @(posedge clk) begin
        if (ram_en)
            ram_rd_data <= {mem[3][ram_rd_addr], mem[2][ram_rd_addr],
                            mem[1][ram_rd_addr], mem[0][ram_rd_addr]};
        else
            ram_rd_data <= 64'd0;
        for (int i = 0; i < 4; i++)
            if (ram_wr_en[i]) mem[i][ram_wr_addr] = ram_wr_data;
        if (ram_wr_en != 4'd0) pulses++;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sx(logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] model_q(int q, int m, int r, bit t);
        int g, s;
        g = t ? 0 : m - (m >>> G);
        s = q + ((r + g - q) >>> A);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic logic [1:0] model_arg(logic [5:0] ns);
        int b = 0;
        for (int i = 1; i < 4; i++)
            if (sx(mem[i][ns]) > sx(mem[b][ns])) b = i;
        return 2'(b);
    endfunction

    function automatic int model_max(logic [5:0] ns);
        int m = sx(mem[0][ns]);
        for (int i = 1; i < 4; i++)
            if (sx(mem[i][ns]) > m) m = sx(mem[i][ns]);
        return m;
    endfunction

    // k = cycles since the request was accepted (0 = no request in flight).
    int          k;
    logic [5:0]  m_s, m_ns;
    logic [1:0]  m_a, m_arg, exp_best;
    logic [15:0] m_nq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= 0;
            exp_best <= 2'd0;
        end else if (k == 0) begin
            if (start) begin
                k     <= 1;
                m_s   <= state;
                m_a   <= action;
                m_ns  <= next_state;
                m_arg <= model_arg(next_state);
                m_nq  <= model_q(sx(mem[action][state]), model_max(next_state),
                                 sx(reward), terminal);
            end
        end else begin
            k <= (k == 6) ? 0 : k + 1;
            if (k == 5) exp_best <= m_arg;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(k >= 1 && k <= 6));
        chk("done", 32'(done), 32'(k == 6));
        chk("ram_en", 32'(ram_en), 32'(k == 1 || k == 2));
        chk("wr_en", 32'(ram_wr_en), (k == 5) ? (32'd1 << m_a) : 32'd0);
        chk("best_action", 32'(best_action), 32'(exp_best));
        if (k == 1) chk("rd_addr_next", 32'(ram_rd_addr), 32'(m_ns));
        if (k == 2) chk("rd_addr_cur", 32'(ram_rd_addr), 32'(m_s));
        if (k == 5) begin
            chk("wr_addr", 32'(ram_wr_addr), 32'(m_s));
            chk("wr_data", 32'(ram_wr_data), 32'(m_nq));
        end
    end

    task automatic set_row(int a, logic [15:0] q0, logic [15:0] q1,
                           logic [15:0] q2, logic [15:0] q3);
        mem[0][a] = q0; mem[1][a] = q1; mem[2][a] = q2; mem[3][a] = q3;
    endtask

    task automatic issue(logic [5:0] s, logic [1:0] a, logic [5:0] ns,
                         logic [15:0] r, logic t);
        @(posedge clk); #1;
        state = s; action = a; next_state = ns; reward = r; terminal = t;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        state = 6'h3F; action = ~a; next_state = 6'h3E;
        reward = 16'h1234; terminal = ~t;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_en"}, 32'(ram_en), 0);
        chk({tag, "_wen"}, 32'(ram_wr_en), 0);
        chk({tag, "_best"}, 32'(best_action), 0);
        chk({tag, "_rda"}, 32'(ram_rd_addr), 0);
        chk({tag, "_wra"}, 32'(ram_wr_addr), 0);
        chk({tag, "_wrd"}, 32'(ram_wr_data), 0);
    endtask

    int p0;

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 64; j++) mem[i][j] = 16'd0;
        ram_rd_data = 64'd0;
        rst_n = 1'b0; start = 1'b0; state = 0; action = 0;
        next_state = 0; reward = 0; terminal = 0;
        #3;
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal
        set_row(9, 16'h0400, 16'h0100, 16'h0000, 16'hFF00);
        mem[1][5] = 16'h0100;
        p0 = pulses;
        issue(5, 1, 9, 16'h0200, 0);
        chk("nom_model", 32'(m_nq), 32'h0220);
        chk("nom_mem", 32'(mem[1][5]), 32'h0220);
        chk("nom_best", 32'(best_action), 0);
        chk("nom_pulses", 32'(pulses - p0), 1);

        // Tie between actions 2 and 3 resolves to 2
        set_row(12, 16'h0010, 16'hFFF0, 16'h0300, 16'h0300);
        mem[3][7] = 16'h0000;
        issue(7, 3, 12, 16'h0000, 0);
        chk("tie_mem", 32'(mem[3][7]), 32'h00A8);
        chk("tie_best", 32'(best_action), 2);

        // Negative delta, arithmetic shift
        set_row(21, 16'hFF00, 16'hFE00, 16'hFF80, 16'hFC00);
        mem[0][20] = 16'h0100;
        issue(20, 0, 21, 16'hFFC0, 0);
        chk("neg_mem", 32'(mem[0][20]), 32'h0094);
        chk("neg_best", 32'(best_action), 2);

        // Negative saturation, all-tie row
        set_row(40, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        mem[3][41] = 16'h8000;
        issue(41, 3, 40, 16'h8000, 0);
        chk("nsat_mem", 32'(mem[3][41]), 32'h8000);
        chk("nsat_best", 32'(best_action), 0);

        // Terminal
        mem[1][5] = 16'h0100;
        issue(5, 1, 9, 16'h0200, 1);
        chk("term_model", 32'(m_nq), 32'h0140);
        chk("term_mem", 32'(mem[1][5]), 32'h0140);
        chk("term_best", 32'(best_action), 0);

        // Positive saturation
        set_row(30, 16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        mem[0][31] = 16'h7F00;
        issue(31, 0, 30, 16'h7F00, 0);
        chk("psat_mem", 32'(mem[0][31]), 32'h7FFF);

        // Start held high: accepts at cycles 1, 8, 15
        set_row(51, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        mem[2][50] = 16'h0000;
        p0 = pulses;
        @(posedge clk); #1;
        state = 50; action = 2; next_state = 51; reward = 16'h0100;
        terminal = 0; start = 1'b1;
        repeat (15) @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("hold_pulses", 32'(pulses - p0), 3);
        chk("hold_mem", 32'(mem[2][50]), 32'h0115);

        // Reset during CALC aborts the write
        set_row(61, 16'h0000, 16'h0000, 16'h0000, 16'h0200);
        mem[1][60] = 16'h0050;
        p0 = pulses;
        @(posedge clk); #1;
        state = 60; action = 1; next_state = 61; reward = 16'h0100;
        terminal = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_pulses", 32'(pulses - p0), 0);
        chk("abort_mem", 32'(mem[1][60]), 32'h0050);
        issue(60, 1, 61, 16'h0100, 0);
        chk("fresh_mem", 32'(mem[1][60]), 32'h00EC);
        chk("fresh_best", 32'(best_action), 3);
        chk("fresh_pulses", 32'(pulses - p0), 1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/q_update_engine.md
Name: q_update_engine

Overview:
Sequential Q-learning update controller that sits directly upstream of four 64x16 action RAMs, one RAM per action, which share read and write addresses.
Per request it:
- reads Q(s',*) from all four RAMs to find maxQ and the argmax;
- reads Q(s,a);
- computes the temporal-difference update with shift-based alpha and gamma;
- writes the new Q(s,a) back to the RAM for action a.
It also reports the greedy action for s' to the policy logic.

Parameters:
A_SHIFT, 2, learning rate alpha = 2^-A_SHIFT (range 0..7)
G_SHIFT, 3, discount gamma = 1 - 2^-G_SHIFT (range 1..7)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
state  input  6  current state index s
action  input  2  action taken a
next_state  input  6  resulting state s'
reward  input  16  signed Q8.8 reward r
terminal  input  1  1 = s' is terminal (maxQ term forced to 0)
busy  output  1  high from cycle after start accepted until done cycle inclusive
done  output  1  one-cycle pulse, write committed
best_action  output  2  argmax_a Q(s',a), valid when done=1, held until next done
ram_en  output  1  read enable to all four RAMs
ram_rd_addr  output  6  shared read address
ram_rd_data  input  64  {Q3,Q2,Q1,Q0} RAM data_out, signed Q8.8 each
ram_wr_addr  output  6  shared write address
ram_wr_data  output  16  new Q value
ram_wr_en  output  4  one-hot write enable, bit a

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - busy, done, ram_en = 0; ram_wr_en = 0000; best_action = 0.
  - ram_rd_addr, ram_wr_addr, ram_wr_data = 0.
  - All internal registers cleared.
  - Reset mid-operation aborts the update with no RAM write.
- RAM model: synchronous read, 1-cycle latency. data_out reads 0 when en=0, so ram_en must be 1 in RD_NEXT and CAP_NEXT. ram_en=0 in all other states.
- Inputs state/action/next_state/reward/terminal are latched on the start-accepting edge. Later input changes are ignored.
- FSM, cycle N = edge at which start is sampled high in IDLE:
  - IDLE: outputs idle; start=1 -> RD_NEXT. start in any other state is ignored; there is no queue.
  - RD_NEXT (N+1): ram_en=1, ram_rd_addr=next_state -> CAP_NEXT.
  - CAP_NEXT (N+2): ram_rd_data holds Q(s',*). Register maxQ = signed max of the four values. Register argmax; ties go to the lowest index. Drive ram_rd_addr=state, ram_en=1 -> CAP_CUR.
  - CAP_CUR (N+3): register q = ram_rd_data slice [16a+15:16a] -> CALC.
  - CALC (N+4): compute new_q and register it -> WRITE.
  - WRITE (N+5): ram_wr_addr=state, ram_wr_data=new_q, ram_wr_en=1<<a for exactly this cycle -> DONE.
  - DONE (N+6): done=1, best_action updated -> IDLE. A start sampled in DONE is ignored; next accept is earliest in IDLE at N+7.
- Start-to-done latency is 6 cycles; the RAM is written exactly once per request.
- Arithmetic, all signed 18-bit:
  - Sign-extend all operands.
  - g = terminal ? 0 : maxQ - (maxQ >>> G_SHIFT)
  - target = r + g
  - delta = target - q
  - sum = q + (delta >>> A_SHIFT), using an arithmetic shift.
  - new_q = sum saturated to [-32768 (0x8000), 32767 (0x7FFF)].
- best_action is computed even when terminal=1.

Test Plan:
- Nominal update: Q(s=5,a=1)=0x0100, Q(s'=9,*)={0x0400,0x0100,0x0000,0xFF00} (a0..a3), r=0x0200, terminal=0.
  -> g=0x0380, new_q=0x0220 written to RAM1 addr 5 at N+5.
  -> done at N+6, best_action=0, busy high N+1..N+6.
- Terminal: same RAM contents, terminal=1 -> new_q=0x0140, best_action=0.
- Positive saturation: q=0x7F00, max=0x7F00, r=0x7F00.
  -> unsaturated sum 0x9AC8, written 0x7FFF.
- Negative saturation and ties: q=0x8000, all Q(s')=0x8000, r=0x8000.
  -> written 0x8000, best_action=0 (all tie).
- Protocol: start held high continuously.
  -> updates accepted only at IDLE, one every 7 cycles.
  -> exactly one ram_wr_en pulse per update, ram_en=0 outside RD_NEXT/CAP_NEXT.
- Reset mid-op: assert rst_n=0 during CALC.
  -> outputs immediately at reset values, no ram_wr_en pulse, RAM contents unchanged.
  -> after release, a fresh start completes normally.
